pwm_multi_channel: RTL
======================

Name: pwm_multi_channel

Overview:
- Parametrised N-channel PWM generator; successor to the single-LED PWM slice.
- Shared prescaler and period counter; per-channel duty, enable and polarity.
- Edge-aligned or center-aligned modes; glitch-free shadow-register updates at period boundaries.
- Instantiated once inside the AXI PWM peripheral, with configuration driven directly from AXI registers.

Parameters:
- NUM_CH, 4, number of PWM channels.
- CNT_W, 16, width of the period counter, period and duty values.
- PSC_W, 8, prescaler width.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- run  input  1  global run; 0 stops and clears the counter.
- mode  input  1  0 = edge-aligned, 1 = center-aligned.
- prescale  input  PSC_W  one counter tick every prescale+1 clocks.
- period  input  CNT_W  counter terminal value P.
- duty  input  NUM_CH*CNT_W  channel i duty in bits [i*CNT_W +: CNT_W].
- ch_en  input  NUM_CH  per-channel enable.
- polarity  input  NUM_CH  1 = invert channel output.
- pwm_out  output  NUM_CH  registered PWM outputs.
- period_end  output  1  one-clock pulse at each period boundary.
- count  output  CNT_W  current counter value, for status readback.

Behaviour:
- Reset (resetn=0, asynchronous):
  - Prescaler, count, direction (up) and all shadow ("active") registers clear to 0.
  - pwm_out = 0 and period_end = 0.
  - Shadow polarity clears to 0, so the idle level after reset is 0.
- Shadow registers:
  - Active copies exist for prescale, period, mode, duty[i], ch_en[i] and polarity[i].
  - They load from the inputs on every clock while run=0, and on the clock a period boundary occurs while run=1.
  - Input changes mid-period have no effect until the next boundary.
- Prescaler:
  - Counts 0..prescale_act; tick asserts on the clock it equals prescale_act, then it wraps to 0.
  - prescale_act=0 gives a tick every clock.
  - Held at 0 while run=0.
- Edge mode counter:
  - Advances on each tick: 0,1,..,P,0,...
  - Boundary is the tick where count=P and count wraps to 0.
  - Period = (P+1)*(prescale+1) clocks.
- Center mode counter:
  - Counts up 0..P, then down P-1..0.
  - Boundary is the tick where count=1 while counting down (count becomes 0); direction flips to up at 0 and to down at P.
  - Period = 2P ticks.
  - P=0 in center mode holds count at 0 and treats every tick as a boundary.
- Run:
  - run=0 forces count=0, direction up, no period_end.
  - On run 0->1 counting starts on the next tick with freshly loaded shadows.
- period_end: registered, high exactly one clk cycle after each boundary tick.
- Output compare, per channel:
  - raw_i = en_act[i] & (count < duty_act[i]).
  - pwm_out[i] <= raw_i ^ pol_act[i], so one clock of latency from count.
  - run=0 or en_act[i]=0 drives the idle level pol_act[i].
- Duty limits:
  - duty=0 gives a constant inactive level.
  - duty >= P+1 gives a constant active level (100%) in edge mode.
  - In center mode, duty > P gives 100%.
- Comparison is unsigned at full CNT_W width; no truncation of period or duty.
- Changing period below the current count mid-period has no effect until the boundary, because the active period governs. No counter runaway is possible.

Test Plan:
- Reset mid-run: resetn=0 asserted asynchronously between clock edges -> pwm_out=0, count=0, period_end=0 immediately, with no clock edge required.
- Edge mode, prescale=0, P=9, duty0=3, ch_en=0001, pol=0 -> pwm_out[0] high 3 clocks of every 10; period_end pulses every 10 clocks; other channels stay 0.
- Center mode, prescale=1, P=4, duty0=2 -> period 16 clocks; pwm_out[0] high during count 0,1 on both up and down legs; one period_end pulse per 16 clocks.
- Shadow update: edge mode, P=9, duty0 changed 3->7 at count=5 -> current period still shows 3 high clocks; the next period shows 7.
- Duty limits: duty0=0 -> constant 0; duty0=10 with P=9 -> constant 1; pol0=1 inverts both cases; ch_en0=0 -> constant pol0.
- Run toggle: run=0 for 20 clocks -> count=0, outputs at the idle level, no period_end; on run=1 the first period_end arrives (P+1)*(prescale+1) clocks later.

Source files
------------

// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator: shared prescaler and edge- or center-aligned period counter,
// with per-channel compare outputs whose configuration is shadowed until each period boundary.
module pwm_multi_channel #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned PSC_W  = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    run,
    input  logic                    mode,
    input  logic [PSC_W-1:0]        prescale,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       polarity,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_end,
    output logic [CNT_W-1:0]        count
);

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_e;

    logic [PSC_W-1:0]        psc_q, psc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    dir_e                    dir_q, dir_d;
    logic [NUM_CH-1:0]       pwm_q, pwm_d;
    logic                    pe_q;

    logic [PSC_W-1:0]        psc_act_q;
    logic [CNT_W-1:0]        per_act_q;
    logic                    mode_act_q;
    logic [NUM_CH*CNT_W-1:0] duty_act_q;
    logic [NUM_CH-1:0]       en_act_q;
    logic [NUM_CH-1:0]       pol_act_q;

    logic                    tick;
    logic                    boundary;
    logic                    load_shadow;

    always_comb begin
        tick     = run && (psc_q == psc_act_q);
        psc_d    = (!run || tick) ? '0 : psc_q + 1'b1;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        boundary = 1'b0;

        if (!run) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (tick) begin
            if (!mode_act_q) begin
                dir_d = DIR_UP;
                if (cnt_q >= per_act_q) begin
                    cnt_d    = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (per_act_q == '0) begin
                cnt_d    = '0;
                dir_d    = DIR_UP;
                boundary = 1'b1;
            end else begin
                case (dir_q)
                    DIR_UP: begin
                        if (cnt_q >= per_act_q) begin
                            // With P=1 the down leg is empty: turning at P lands directly on the boundary.
                            if (per_act_q == CNT_W'(1)) begin
                                cnt_d    = '0;
                                boundary = 1'b1;
                            end else begin
                                cnt_d = per_act_q - 1'b1;
                                dir_d = DIR_DOWN;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    DIR_DOWN: begin
                        if (cnt_q <= CNT_W'(1)) begin
                            cnt_d    = '0;
                            dir_d    = DIR_UP;
                            boundary = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        cnt_d = '0;
                        dir_d = DIR_UP;
                    end
                endcase
            end
        end

        load_shadow = !run || boundary;

        // Compare uses the pre-edge count and shadows, giving one clock of output latency.
        pwm_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = (run && en_act_q[i] && (cnt_q < duty_act_q[i*CNT_W +: CNT_W])) ^ pol_act_q[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            psc_q      <= '0;
            cnt_q      <= '0;
            dir_q      <= DIR_UP;
            pwm_q      <= '0;
            pe_q       <= 1'b0;
            psc_act_q  <= '0;
            per_act_q  <= '0;
            mode_act_q <= 1'b0;
            duty_act_q <= '0;
            en_act_q   <= '0;
            pol_act_q  <= '0;
        end else begin
            psc_q <= psc_d;
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            pwm_q <= pwm_d;
            pe_q  <= boundary;
            if (load_shadow) begin
                psc_act_q  <= prescale;
                per_act_q  <= period;
                mode_act_q <= mode;
                duty_act_q <= duty;
                en_act_q   <= ch_en;
                pol_act_q  <= polarity;
            end
        end
    end

    assign pwm_out    = pwm_q;
    assign period_end = pe_q;
    assign count      = cnt_q;

endmodule
